// File: rtl/rs_decode_pkg.sv
// Shared constants and state encoding for the Reed-Solomon decoder frame sequencer.
package rs_decode_pkg;

  localparam int RS_N     = 255;
  localparam int RS_DELAY = 264;
  localparam int RS_CNT_W = 9;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } inState_t;

endpackage

// File: rtl/rs_delay_slot.sv
// One delay slot: a loadable down-counter that fires when it counts down to zero.
module rs_delay_slot
  import rs_decode_pkg::*;
#(
  parameter int CNT_W = RS_CNT_W,
  parameter int LOAD  = RS_DELAY - 1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic enable,
  input  logic load,
  output logic busy,
  output logic fire
);

  localparam logic [CNT_W-1:0] LOAD_C = CNT_W'(LOAD);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // Fires on the enabled cycle whose edge takes the count from 1 to 0.
  assign fire = enable & busy & (cnt == ONE_C);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (enable) begin
      if (load) begin
        cnt  <= LOAD_C;
        busy <= 1'b1;
      end else if (busy) begin
        cnt <= cnt - ONE_C;
        if (fire) begin
          busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/rs_decode_frame_ctrl.sv
// Frame sequencer: input codeword FSM, delay-slot allocator and output framing counter.
// Handshake: no valid/ready; every state change is qualified by enable, outputs hold while enable=0.
module rs_decode_frame_ctrl
  import rs_decode_pkg::*;
#(
  parameter int N     = RS_N,
  parameter int DELAY = RS_DELAY,
  parameter int CNT_W = RS_CNT_W
) (
  input  logic CLK,
  input  logic RESET,
  input  logic enable,
  input  logic sync,
  output logic delayEnable,
  output logic syndromeStart,
  output logic syndromeLast,
  output logic outSync,
  output logic outValid,
  output logic outLast,
  output logic frameErr,
  output logic overflow,
  output logic dbgState
);

  localparam logic [CNT_W-1:0] N_C   = CNT_W'(N);
  localparam logic [CNT_W-1:0] NM1_C = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  inState_t         state, stateNext;
  logic [CNT_W-1:0] inCnt, inCntNext;
  logic             accept, lastNext, errNext;
  logic [CNT_W-1:0] outCnt;
  logic             busy0, busy1, fire0, fire1;
  logic             free0, free1, load0, load1, drop, fireAny;

  assign delayEnable = enable;
  assign dbgState    = (state == RUN);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      inCnt <= '0;
    end else begin
      state <= stateNext;
      inCnt <= inCntNext;
    end
  end

  // inCnt==N marks the cycle right after the last symbol: sync there is a clean back-to-back start.
  always_comb begin
    stateNext = state;
    inCntNext = inCnt;
    accept    = 1'b0;
    lastNext  = 1'b0;
    errNext   = 1'b0;
    if (enable) begin
      case (state)
        IDLE: begin
          if (sync) begin
            accept    = 1'b1;
            stateNext = RUN;
            inCntNext = ONE_C;
          end
        end
        RUN: begin
          if (sync) begin
            accept    = 1'b1;
            inCntNext = ONE_C;
            errNext   = (inCnt != N_C);
          end else if (inCnt == N_C) begin
            stateNext = IDLE;
            inCntNext = '0;
          end else begin
            inCntNext = inCnt + ONE_C;
            lastNext  = (inCnt == NM1_C);
          end
        end
        default: begin
          stateNext = IDLE;
          inCntNext = '0;
        end
      endcase
    end
  end

  // A slot that fires on this edge counts as free and may be re-armed at once.
  always_comb begin
    free0   = ~busy0 | fire0;
    free1   = ~busy1 | fire1;
    load0   = accept & free0;
    load1   = accept & ~free0 & free1;
    drop    = accept & ~free0 & ~free1;
    fireAny = fire0 | fire1;
  end

  rs_delay_slot #(.CNT_W(CNT_W), .LOAD(DELAY - 1)) slot0 (
    .CLK    (CLK),
    .RESET  (RESET),
    .enable (enable),
    .load   (load0),
    .busy   (busy0),
    .fire   (fire0)
  );

  rs_delay_slot #(.CNT_W(CNT_W), .LOAD(DELAY - 1)) slot1 (
    .CLK    (CLK),
    .RESET  (RESET),
    .enable (enable),
    .load   (load1),
    .busy   (busy1),
    .fire   (fire1)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      syndromeStart <= 1'b0;
      syndromeLast  <= 1'b0;
      frameErr      <= 1'b0;
      overflow      <= 1'b0;
      outSync       <= 1'b0;
      outValid      <= 1'b0;
      outLast       <= 1'b0;
      outCnt        <= '0;
    end else if (enable) begin
      syndromeStart <= accept;
      syndromeLast  <= lastNext;
      frameErr      <= errNext;
      if (drop) begin
        overflow <= 1'b1;
      end
      // A firing slot always wins: it starts a new output frame, truncating any frame in progress.
      if (fireAny) begin
        outSync  <= 1'b1;
        outValid <= 1'b1;
        outLast  <= 1'b0;
        outCnt   <= NM1_C;
      end else begin
        outSync <= 1'b0;
        if (outValid) begin
          if (outCnt == '0) begin
            outValid <= 1'b0;
            outLast  <= 1'b0;
          end else begin
            outCnt  <= outCnt - ONE_C;
            outLast <= (outCnt == ONE_C);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_decode_frame_ctrl.sv
// Bench for rs_decode_frame_ctrl: scenario table, reset-mid-frame sequence and random stimulus,
// all checked every cycle against a frame-level reference model.
module tb_rs_decode_frame_ctrl;
  import rs_decode_pkg::*;

  localparam int N = RS_N;
  localparam int D = RS_DELAY;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic enable = 1'b0;
  logic sync = 1'b0;
  logic delayEnable, syndromeStart, syndromeLast, outSync, outValid, outLast;
  logic frameErr, overflow, dbgState;

  always #5 CLK = ~CLK;

  rs_decode_frame_ctrl dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .enable        (enable),
    .sync          (sync),
    .delayEnable   (delayEnable),
    .syndromeStart (syndromeStart),
    .syndromeLast  (syndromeLast),
    .outSync       (outSync),
    .outValid      (outValid),
    .outLast       (outLast),
    .frameErr      (frameErr),
    .overflow      (overflow),
    .dbgState      (dbgState)
  );

  int vecs = 0;
  int miscmp = 0;

  // Reference model: c = enabled cycles since reset, pos = symbols into the current input frame,
  // sq = enabled-cycle indices at which output frames begin.
  int c;
  int pos;
  bit mSS, mSL, mFE, mOvf;
  int sq[$];

  int firstSync, lastLast, nLast, nSynLast, nFE;

  typedef struct {
    int s0, s1, s2;
    bit gate;
    int expFirst, expLastLast, expNLast, expNSynLast, expNFE;
    bit expOvf;
  } scen_t;

  scen_t tbl[5];

  task automatic chk(input string nm, input logic act, input logic exp);
    vecs++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s at enabled cycle %0d: got %b, expected %b", nm, c, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      miscmp++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit m_out_sync();
    foreach (sq[i]) if (sq[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_out_valid();
    foreach (sq[i]) if (sq[i] <= c && c <= sq[i] + N - 1) return 1'b1;
    return 1'b0;
  endfunction

  // A frame ends with outLast only if no later frame started before its final symbol.
  function automatic bit m_out_last();
    bit cut;
    foreach (sq[i]) begin
      if (c == sq[i] + N - 1) begin
        cut = 1'b0;
        foreach (sq[j]) if (sq[j] > sq[i] && sq[j] <= c) cut = 1'b1;
        if (!cut) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    c = 0; pos = 0;
    mSS = 0; mSL = 0; mFE = 0; mOvf = 0;
    sq.delete();
  endtask

  task automatic model_edge(input bit sy);
    int busy;
    mSS = 0; mSL = 0; mFE = 0;
    if (sy) begin
      mSS = 1;
      if (pos > 0 && pos < N) mFE = 1;
      busy = 0;
      foreach (sq[i]) if (sq[i] > c + 1) busy++;
      if (busy < 2) sq.push_back(c + D);
      else mOvf = 1;
      pos = 1;
    end else if (pos > 0) begin
      if (pos == N - 1) mSL = 1;
      if (pos == N) pos = 0;
      else pos++;
    end
    c++;
    while (sq.size() > 0 && sq[0] + N < c) void'(sq.pop_front());
  endtask

  task automatic check_all();
    chk("delayEnable", delayEnable, enable);
    chk("syndromeStart", syndromeStart, mSS);
    chk("syndromeLast", syndromeLast, mSL);
    chk("frameErr", frameErr, mFE);
    chk("overflow", overflow, mOvf);
    chk("outSync", outSync, m_out_sync());
    chk("outValid", outValid, m_out_valid());
    chk("outLast", outLast, m_out_last());
    chk("dbgState", dbgState, pos > 0);
  endtask

  task automatic step(input bit en, input bit sy);
    enable = en;
    sync = sy;
    @(negedge CLK);
    check_all();
    if (en) begin
      if (outSync && firstSync < 0) firstSync = c;
      if (outLast) begin nLast++; lastLast = c; end
      if (syndromeLast) nSynLast++;
      if (frameErr) nFE++;
    end
    @(posedge CLK);
    #1;
    if (en) model_edge(sy);
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    enable = 1'b0;
    sync = 1'b0;
    model_reset();
    @(negedge CLK);
    check_all();
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    firstSync = -1; lastLast = -1; nLast = 0; nSynLast = 0; nFE = 0;
  endtask

  task automatic run_scenario(input int idx);
    int g;
    bit en, sy;
    do_reset();
    g = 0;
    while (c < 900) begin
      en = tbl[idx].gate ? ((g % 3) != 2) : 1'b1;
      g++;
      sy = en && (c == tbl[idx].s0 || c == tbl[idx].s1 || c == tbl[idx].s2);
      step(en, sy);
    end
    chk_int($sformatf("scen%0d first outSync", idx), firstSync, tbl[idx].expFirst);
    chk_int($sformatf("scen%0d final outLast", idx), lastLast, tbl[idx].expLastLast);
    chk_int($sformatf("scen%0d outLast count", idx), nLast, tbl[idx].expNLast);
    chk_int($sformatf("scen%0d syndromeLast count", idx), nSynLast, tbl[idx].expNSynLast);
    chk_int($sformatf("scen%0d frameErr count", idx), nFE, tbl[idx].expNFE);
    chk_int($sformatf("scen%0d overflow", idx), int'(overflow), int'(tbl[idx].expOvf));
  endtask

  initial begin
    bit en, sy;
    tbl[0] = '{10, -1, -1, 1'b0, 274, 528, 1, 1, 0, 1'b0};
    tbl[1] = '{10, 265, -1, 1'b0, 274, 783, 2, 2, 0, 1'b0};
    tbl[2] = '{10, -1, -1, 1'b1, 274, 528, 1, 1, 0, 1'b0};
    tbl[3] = '{10, 110, -1, 1'b0, 274, 628, 1, 1, 1, 1'b0};
    tbl[4] = '{10, 60, 110, 1'b0, 274, 578, 1, 1, 2, 1'b1};

    for (int i = 0; i < 5; i++) run_scenario(i);

    // Reset in the middle of an output frame, then a fresh codeword.
    do_reset();
    while (c < 300) step(1'b1, c == 10);
    #2;
    RESET = 1'b0;
    #1;
    chk("rst syndromeStart", syndromeStart, 1'b0);
    chk("rst syndromeLast", syndromeLast, 1'b0);
    chk("rst outSync", outSync, 1'b0);
    chk("rst outValid", outValid, 1'b0);
    chk("rst outLast", outLast, 1'b0);
    chk("rst frameErr", frameErr, 1'b0);
    chk("rst overflow", overflow, 1'b0);
    chk("rst dbgState", dbgState, 1'b0);
    model_reset();
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    firstSync = -1; lastLast = -1; nLast = 0;
    while (c < 600) step(1'b1, c == 10);
    chk_int("post-reset first outSync", firstSync, 274);
    chk_int("post-reset outLast", lastLast, 528);

    // Random enable gating and sync placement, with one reset midway.
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      if (i == 2500) do_reset();
      en = ($urandom_range(0, 9) < 8);
      if (pos == N) sy = ($urandom_range(0, 1) == 1);
      else if (pos == 0) sy = ($urandom_range(0, 29) == 0);
      else sy = ($urandom_range(0, 299) == 0);
      step(en, sy && en);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
